// File: rtl/uart_rx16x.sv
// rtl/uart_rx16x.sv - 16x-oversampled UART receiver with framing and overrun flags
// Start bit is confirmed at MID_TICK, then each data and stop bit is sampled at tick 15 of its window.
module uart_rx16x #(
   parameter int DATA_BITS = 8,
   parameter int MID_TICK  = 7
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 tick16,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ack,
   output logic                 framing_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [3:0]    MID   = 4'(MID_TICK);
   localparam logic [BW-1:0] LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] B_ONE = BW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state, state_n;
   logic                 rx_meta, rxs;
   logic [3:0]           tcnt, tcnt_n;
   logic [BW-1:0]        bcnt, bcnt_n;
   logic [DATA_BITS-1:0] sr, sr_n;
   logic                 stop_good, stop_bad;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      tcnt_n    = tcnt;
      bcnt_n    = bcnt;
      sr_n      = sr;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (tick16 && !rxs) begin
               state_n = START;
               tcnt_n  = 4'd0;
            end
         end
         START: begin
            if (tick16) begin
               if (tcnt == MID) begin
                  tcnt_n = 4'd0;
                  if (!rxs) begin
                     state_n = DATA;
                     bcnt_n  = '0;
                  end else begin
                     // glitch shorter than half a bit: drop it silently
                     state_n = IDLE;
                  end
               end else begin
                  tcnt_n = tcnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick16) begin
               tcnt_n = tcnt + 4'd1;
               if (tcnt == 4'd15) begin
                  sr_n = {rxs, sr[DATA_BITS-1:1]};
                  if (bcnt == LAST) begin
                     state_n = STOP;
                     bcnt_n  = '0;
                     tcnt_n  = 4'd0;
                  end else begin
                     bcnt_n = bcnt + B_ONE;
                  end
               end
            end
         end
         STOP: begin
            if (tick16) begin
               if (tcnt == 4'd15) begin
                  state_n   = IDLE;
                  tcnt_n    = 4'd0;
                  stop_good = rxs;
                  stop_bad  = !rxs;
               end else begin
                  tcnt_n = tcnt + 4'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tcnt_n  = 4'd0;
            bcnt_n  = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         rx_meta     <= 1'b1;
         rxs         <= 1'b1;
         tcnt        <= 4'd0;
         bcnt        <= '0;
         sr          <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         rx_meta     <= rx;
         rxs         <= rx_meta;
         tcnt        <= tcnt_n;
         bcnt        <= bcnt_n;
         sr          <= sr_n;
         framing_err <= stop_bad;
         // an ack landing with the load counts as consumption of the old byte
         overrun_err <= stop_good && data_valid && !data_ack;
         if (stop_good) begin
            data_out   <= sr;
            data_valid <= 1'b1;
         end else if (data_ack) begin
            data_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx16x.sv
// tb/tb_uart_rx16x.sv - directed and randomized frames checked against a frame-level receiver model
module tb_uart_rx16x;

   logic       CLOCK_50 = 1'b0;
   logic       reset, tick16, rx, data_ack;
   logic [7:0] data_out;
   logic       data_valid, framing_err, overrun_err, busy;

   int checks = 0, failures = 0;
   int fe_cycles = 0, ov_cycles = 0;
   logic [7:0] m_data;
   bit   m_valid;
   int   m_fe, m_ov;
   bit   irregular;

   uart_rx16x #(.DATA_BITS(8), .MID_TICK(7)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .tick16(tick16), .rx(rx),
      .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
      .framing_err(framing_err), .overrun_err(overrun_err), .busy(busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // pulse widths are measured as high cycles, so a stuck flag shows up as an excess
   always @(negedge CLOCK_50) begin
      if (framing_err === 1'b1) fe_cycles++;
      if (overrun_err === 1'b1) ov_cycles++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_tick(input bit ack);
      int gap;
      gap = irregular ? int'($urandom_range(7, 3)) : 4;
      repeat (gap - 1) cyc();
      tick16   = 1'b1;
      data_ack = ack;
      cyc();
      tick16   = 1'b0;
      data_ack = 1'b0;
   endtask

   task automatic model_stop(input logic [7:0] d, input bit good, input bit ack);
      if (good) begin
         if (m_valid && !ack) m_ov++;
         m_data  = d;
         m_valid = 1'b1;
      end else begin
         m_fe++;
      end
   endtask

   task automatic ack_pulse(input string tag);
      data_ack = 1'b1;
      cyc();
      data_ack = 1'b0;
      m_valid  = 1'b0;
      chk({tag, "_ack_valid"}, data_valid, m_valid);
      chk({tag, "_ack_data"}, data_out, m_data);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit good, input bit ack_stop, input string tag);
      logic [9:0] bits;
      bits = {good, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rx = bits[b];
         for (int t = 1; t <= 16; t++) begin
            if (b == 9 && t == 9) begin
               chk({tag, "_pre_valid"}, data_valid, m_valid);
               do_tick(ack_stop);
               model_stop(d, good, ack_stop);
               chk({tag, "_valid"}, data_valid, m_valid);
               chk({tag, "_data"}, data_out, m_data);
               chk({tag, "_busy_after_stop"}, busy, 0);
               chk({tag, "_fe_now"}, framing_err, !good);
            end else begin
               do_tick(1'b0);
            end
         end
      end
      rx = 1'b1;
      repeat (20) do_tick(1'b0);
      chk({tag, "_fe_count"}, fe_cycles, m_fe);
      chk({tag, "_ov_count"}, ov_cycles, m_ov);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_valid"}, data_valid, m_valid);
      chk({tag, "_idle_data"}, data_out, m_data);
   endtask

   initial begin
      reset = 1'b1; rx = 1'b1; tick16 = 1'b0; data_ack = 1'b0; irregular = 1'b0;
      m_data = 8'h00; m_valid = 1'b0; m_fe = 0; m_ov = 0;
      repeat (3) cyc();
      chk("rst_data", data_out, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fe", framing_err, 0);
      chk("rst_ov", overrun_err, 0);
      reset = 1'b0;
      repeat (2) cyc();

      send_frame(8'hA5, 1'b1, 1'b0, "a5");
      ack_pulse("a5");

      // line low for 4 ticks only: must abort at the mid-bit check
      rx = 1'b0;
      repeat (4) do_tick(1'b0);
      rx = 1'b1;
      repeat (4) do_tick(1'b0);
      chk("false_busy_before_mid", busy, 1);
      do_tick(1'b0);
      chk("false_busy_at_mid", busy, 0);
      repeat (10) do_tick(1'b0);
      chk("false_valid", data_valid, 0);
      chk("false_fe", fe_cycles, m_fe);
      chk("false_ov", ov_cycles, m_ov);

      send_frame(8'h3C, 1'b0, 1'b0, "3c_bad");

      send_frame(8'h11, 1'b1, 1'b0, "11");
      send_frame(8'h22, 1'b1, 1'b0, "22_ovr");
      ack_pulse("22");
      ack_pulse("22_again");

      send_frame(8'h44, 1'b1, 1'b0, "44");
      send_frame(8'h55, 1'b1, 1'b1, "55_ack_coincide");
      ack_pulse("55");

      // reset in the middle of data bit 4 of 0xFF
      rx = 1'b0;
      repeat (16) do_tick(1'b0);
      rx = 1'b1;
      repeat (16 * 4 + 5) do_tick(1'b0);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", data_valid, 0);
      chk("mid_rst_data", data_out, 0);
      m_data = 8'h00; m_valid = 1'b0;
      repeat (2) cyc();
      reset = 1'b0;
      repeat (16 * 5) do_tick(1'b0);
      chk("mid_after_busy", busy, 0);
      chk("mid_after_valid", data_valid, 0);
      chk("mid_after_fe", fe_cycles, m_fe);
      chk("mid_after_ov", ov_cycles, m_ov);
      send_frame(8'h81, 1'b1, 1'b0, "81");
      ack_pulse("81");

      irregular = 1'b1;
      send_frame(8'h5A, 1'b1, 1'b0, "5a_irreg");

      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         bit good;
         d = 8'($urandom);
         good = ($urandom_range(3, 0) != 0);
         irregular = ($urandom_range(1, 0) != 0);
         if ($urandom_range(1, 0) != 0) ack_pulse("rnd");
         send_frame(d, good, 1'b0, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
